// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO family.
// fifo_status_t bit order matches the bus slave's STATUS register layout.
package fifo_pkg;

    // MSB first: empty is STATUS[5], almost_full is STATUS[0]
    typedef struct packed {
        logic empty;
        logic full;
        logic overflow;
        logic underflow;
        logic almost_empty;
        logic almost_full;
    } fifo_status_t;

    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Wraps at depth-1 explicitly so non-power-of-two depths work
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Handshake/status bundle between the register slave (master side) and the FIFO (slave side).
interface sync_fifo_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int PW    = fifo_pkg::ptr_width(DEPTH),
    parameter int LW    = fifo_pkg::level_width(DEPTH)
);
    logic             wr_request;
    logic [WIDTH-1:0] wr_data;
    logic             rd_request;
    logic [WIDTH-1:0] rd_data;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic [LW-1:0]    level;
    logic             overflow;
    logic             underflow;
    logic             clear_overflow_request;
    logic             clear_underflow_request;
    logic [PW-1:0]    wr_index;
    logic [PW-1:0]    rd_index;

    modport master (
        output wr_request, wr_data, rd_request,
        output clear_overflow_request, clear_underflow_request,
        input  rd_data, empty, full, almost_empty, almost_full,
        input  level, overflow, underflow, wr_index, rd_index
    );

    modport slave (
        input  wr_request, wr_data, rd_request,
        input  clear_overflow_request, clear_underflow_request,
        output rd_data, empty, full, almost_empty, almost_full,
        output level, overflow, underflow, wr_index, rd_index
    );

endinterface

// File: rtl/fifo_mem_sp.sv
// WIDTH x DEPTH storage with one write port and one registered read port.
// WRITE_FIRST forwards same-address write data to the read register (used for fall-through).
module fifo_mem_sp
    import fifo_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 16,
    parameter int AW          = ptr_width(DEPTH),
    parameter bit WRITE_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_reg;

    // Storage is deliberately left unreset so it maps onto RAM primitives
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_reg <= '0;
        end else if (re) begin
            if (WRITE_FIRST && we && (waddr == raddr)) begin
                rdata_reg <= wdata;
            end else begin
                rdata_reg <= mem[raddr];
            end
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO: pointers, fill level, registered flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through; otherwise rd_data is registered on pop.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int PW       = ptr_width(DEPTH),
    parameter int LW       = level_width(DEPTH)
) (
    input logic              clk,
    input logic              reset,
    sync_fifo_param_if.slave bus
);

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [LW-1:0] level_reg, level_next;
    fifo_status_t  status_reg, status_next;
    logic          wr_ok, rd_ok;
    logic          overflow_next, underflow_next;
    logic          mem_we, mem_re;
    logic [PW-1:0] mem_raddr;

    function automatic fifo_status_t level_status(input logic [LW-1:0] lvl,
                                                  input logic ovf, input logic unf);
        fifo_status_t s;
        s.empty        = (lvl == '0);
        s.full         = (int'(lvl) == DEPTH);
        s.overflow     = ovf;
        s.underflow    = unf;
        s.almost_empty = (int'(lvl) <= AE_LEVEL);
        s.almost_full  = (int'(lvl) >= AF_LEVEL);
        return s;
    endfunction

    // A pop frees a slot this cycle, so a full FIFO still takes a write alongside a read;
    // an empty FIFO never serves a read, even when a write lands in the same cycle.
    always_comb begin
        rd_ok = bus.rd_request && !status_reg.empty;
        wr_ok = bus.wr_request && (!status_reg.full || rd_ok);

        wr_ptr_next = wr_ptr_reg;
        if (wr_ok) begin
            wr_ptr_next = PW'(next_ptr(32'(wr_ptr_reg), DEPTH));
        end
        rd_ptr_next = rd_ptr_reg;
        if (rd_ok) begin
            rd_ptr_next = PW'(next_ptr(32'(rd_ptr_reg), DEPTH));
        end

        level_next = level_reg;
        if (wr_ok && !rd_ok) begin
            level_next = level_reg + 1'b1;
        end else if (!wr_ok && rd_ok) begin
            level_next = level_reg - 1'b1;
        end

        // Error events beat a simultaneous clear
        overflow_next = status_reg.overflow;
        if (bus.wr_request && !wr_ok) begin
            overflow_next = 1'b1;
        end else if (bus.clear_overflow_request) begin
            overflow_next = 1'b0;
        end
        underflow_next = status_reg.underflow;
        if (bus.rd_request && !rd_ok) begin
            underflow_next = 1'b1;
        end else if (bus.clear_underflow_request) begin
            underflow_next = 1'b0;
        end

        status_next = level_status(level_next, overflow_next, underflow_next);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            status_reg <= level_status('0, 1'b0, 1'b0);
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
            status_reg <= status_next;
        end
    end

    assign mem_we = wr_ok && !reset;

`ifdef SYNC_FIFO_FWFT_EN
    // Keep the read register loaded with the word that will be at the head next cycle;
    // a write into an empty FIFO is forwarded straight into it.
    localparam bit MEM_WRITE_FIRST = 1'b1;
    assign mem_re    = wr_ok || rd_ok;
    assign mem_raddr = rd_ptr_next;
`else
    // Read-first: a full FIFO doing push+pop reads the old head before it is overwritten
    localparam bit MEM_WRITE_FIRST = 1'b0;
    assign mem_re    = rd_ok;
    assign mem_raddr = rd_ptr_reg;
`endif

    fifo_mem_sp #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .AW          (PW),
        .WRITE_FIRST (MEM_WRITE_FIRST)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .waddr (wr_ptr_reg),
        .wdata (bus.wr_data),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (bus.rd_data)
    );

    assign bus.empty        = status_reg.empty;
    assign bus.full         = status_reg.full;
    assign bus.almost_empty = status_reg.almost_empty;
    assign bus.almost_full  = status_reg.almost_full;
    assign bus.overflow     = status_reg.overflow;
    assign bus.underflow    = status_reg.underflow;
    assign bus.level        = level_reg;
    assign bus.wr_index     = wr_ptr_reg;
    assign bus.rd_index     = rd_ptr_reg;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DEPTH=16 and DEPTH=15 instances).
// Expected read data follows SYNC_FIFO_FWFT_EN when that macro is defined.
module tb_sync_fifo_param;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sync_fifo_param_if #(.WIDTH(8), .DEPTH(16)) f16 ();
    sync_fifo_param_if #(.WIDTH(8), .DEPTH(15)) f15 ();

    sync_fifo_param #(.WIDTH(8), .DEPTH(16)) dut16 (.clk(clk), .reset(reset), .bus(f16.slave));
    sync_fifo_param #(.WIDTH(8), .DEPTH(15)) dut15 (.clk(clk), .reset(reset), .bus(f15.slave));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model for the DEPTH=16 instance: a queue of stored words
    logic [7:0]  mq[$];
    int unsigned m_wr_cnt, m_rd_cnt;
    bit          m_ovf, m_unf;
    logic [7:0]  m_rd;

    task automatic compare_model(input string tag);
        check({tag, ".level"}, 32'(f16.level), mq.size());
        check({tag, ".empty"}, 32'(f16.empty), 32'(mq.size() == 0));
        check({tag, ".full"}, 32'(f16.full), 32'(mq.size() == 16));
        check({tag, ".almost_empty"}, 32'(f16.almost_empty), 32'(mq.size() <= 2));
        check({tag, ".almost_full"}, 32'(f16.almost_full), 32'(mq.size() >= 14));
        check({tag, ".overflow"}, 32'(f16.overflow), 32'(m_ovf));
        check({tag, ".underflow"}, 32'(f16.underflow), 32'(m_unf));
        check({tag, ".wr_index"}, 32'(f16.wr_index), m_wr_cnt % 16);
        check({tag, ".rd_index"}, 32'(f16.rd_index), m_rd_cnt % 16);
`ifdef SYNC_FIFO_FWFT_EN
        if (mq.size() > 0) check({tag, ".rd_data"}, 32'(f16.rd_data), 32'(m_rd));
`else
        check({tag, ".rd_data"}, 32'(f16.rd_data), 32'(m_rd));
`endif
    endtask

    task automatic step(input bit w, input logic [7:0] d, input bit r, input bit co, input bit cu,
                        input string tag);
        bit rok, wok;
        logic [7:0] popped;
        f16.wr_request = w;
        f16.wr_data    = d;
        f16.rd_request = r;
        f16.clear_overflow_request  = co;
        f16.clear_underflow_request = cu;
        rok = r && (mq.size() > 0);
        wok = w && ((mq.size() < 16) || rok);
        if (rok) begin
            popped = mq.pop_front();
`ifndef SYNC_FIFO_FWFT_EN
            m_rd = popped;
`endif
            m_rd_cnt++;
        end
        if (wok) begin
            mq.push_back(d);
            m_wr_cnt++;
        end
`ifdef SYNC_FIFO_FWFT_EN
        if (mq.size() > 0) m_rd = mq[0];
`endif
        if (w && !wok) m_ovf = 1'b1;
        else if (co)   m_ovf = 1'b0;
        if (r && !rok) m_unf = 1'b1;
        else if (cu)   m_unf = 1'b0;
        @(posedge clk);
        #1;
        compare_model(tag);
    endtask

    task automatic idle16();
        f16.wr_request = 1'b0;
        f16.wr_data    = 8'h00;
        f16.rd_request = 1'b0;
        f16.clear_overflow_request  = 1'b0;
        f16.clear_underflow_request = 1'b0;
    endtask

    // Reset with optional competing requests to show reset overrides them
    task automatic do_reset(input bit busy);
        reset = 1'b1;
        f16.wr_request = busy;
        f16.wr_data    = 8'hEE;
        f16.rd_request = busy;
        f16.clear_overflow_request  = 1'b0;
        f16.clear_underflow_request = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle16();
        mq.delete();
        m_wr_cnt = 0;
        m_rd_cnt = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_rd  = 8'h00;
        check("rst.level", 32'(f16.level), 0);
        check("rst.empty", 32'(f16.empty), 1);
        check("rst.full", 32'(f16.full), 0);
        check("rst.almost_empty", 32'(f16.almost_empty), 1);
        check("rst.almost_full", 32'(f16.almost_full), 0);
        check("rst.overflow", 32'(f16.overflow), 0);
        check("rst.underflow", 32'(f16.underflow), 0);
        check("rst.rd_data", 32'(f16.rd_data), 0);
        check("rst.wr_index", 32'(f16.wr_index), 0);
        check("rst.rd_index", 32'(f16.rd_index), 0);
    endtask

    typedef struct {
        bit         w;
        logic [7:0] d;
        bit         r;
        bit         co;
        bit         cu;
        int         lvl;
        bit         ovf;
        bit         unf;
        logic [7:0] rd;
        bit         chk_rd;
    } vec_t;

    function automatic vec_t mk(input bit w, input logic [7:0] d, input bit r, input bit co,
                                input bit cu, input int lvl, input bit ovf, input bit unf,
                                input logic [7:0] rd, input bit chk_rd);
        vec_t v;
        v.w = w; v.d = d; v.r = r; v.co = co; v.cu = cu;
        v.lvl = lvl; v.ovf = ovf; v.unf = unf; v.rd = rd; v.chk_rd = chk_rd;
        return v;
    endfunction

    vec_t vt[35];

    initial begin
        int n;
        logic [7:0] prev_wi;
        bit wrapped;
        int wbias[3];
        bit w, r, co, cu;

        // Directed table: fill, overflow, drain, underflow, clear (DEPTH=16)
        n = 0;
        for (int i = 1; i <= 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
            vt[n++] = mk(1, 8'(i), 0, 0, 0, i, 0, 0, 8'h01, 1);
`else
            vt[n++] = mk(1, 8'(i), 0, 0, 0, i, 0, 0, 8'h00, 1);
`endif
        end
`ifdef SYNC_FIFO_FWFT_EN
        vt[n++] = mk(1, 8'hFF, 0, 0, 0, 16, 1, 0, 8'h01, 1);
`else
        vt[n++] = mk(1, 8'hFF, 0, 0, 0, 16, 1, 0, 8'h00, 1);
`endif
        for (int i = 1; i <= 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
            vt[n++] = mk(0, 8'h00, 1, 0, 0, 16 - i, 1, 0, 8'(i + 1), i < 16);
`else
            vt[n++] = mk(0, 8'h00, 1, 0, 0, 16 - i, 1, 0, 8'(i), 1);
`endif
        end
`ifdef SYNC_FIFO_FWFT_EN
        vt[n++] = mk(0, 8'h00, 1, 0, 0, 0, 1, 1, 8'h10, 0);
        vt[n++] = mk(0, 8'h00, 0, 1, 1, 0, 0, 0, 8'h10, 0);
`else
        vt[n++] = mk(0, 8'h00, 1, 0, 0, 0, 1, 1, 8'h10, 1);
        vt[n++] = mk(0, 8'h00, 0, 1, 1, 0, 0, 0, 8'h10, 1);
`endif

        reset = 1'b1;
        idle16();
        f15.wr_request = 1'b0;
        f15.wr_data    = 8'h00;
        f15.rd_request = 1'b0;
        f15.clear_overflow_request  = 1'b0;
        f15.clear_underflow_request = 1'b0;
        @(posedge clk);
        #1;
        do_reset(1'b0);

        for (int k = 0; k < n; k++) begin
            f16.wr_request = vt[k].w;
            f16.wr_data    = vt[k].d;
            f16.rd_request = vt[k].r;
            f16.clear_overflow_request  = vt[k].co;
            f16.clear_underflow_request = vt[k].cu;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.level", k), 32'(f16.level), vt[k].lvl);
            check($sformatf("vec%0d.empty", k), 32'(f16.empty), 32'(vt[k].lvl == 0));
            check($sformatf("vec%0d.full", k), 32'(f16.full), 32'(vt[k].lvl == 16));
            check($sformatf("vec%0d.almost_empty", k), 32'(f16.almost_empty), 32'(vt[k].lvl <= 2));
            check($sformatf("vec%0d.almost_full", k), 32'(f16.almost_full), 32'(vt[k].lvl >= 14));
            check($sformatf("vec%0d.overflow", k), 32'(f16.overflow), 32'(vt[k].ovf));
            check($sformatf("vec%0d.underflow", k), 32'(f16.underflow), 32'(vt[k].unf));
            if (vt[k].chk_rd) check($sformatf("vec%0d.rd_data", k), 32'(f16.rd_data), 32'(vt[k].rd));
            $display("vec %0d: w=%0d d=%02h r=%0d level=%0d rd_data=%02h", k, vt[k].w, vt[k].d,
                     vt[k].r, f16.level, f16.rd_data);
        end

        // Full with simultaneous push+pop: accepted, no overflow, 0xAA comes out last
        do_reset(1'b0);
        for (int i = 0; i < 16; i++) step(1, 8'(8'h20 + i), 0, 0, 0, "fill");
        step(1, 8'hAA, 1, 0, 0, "full_wr_rd");
        check("full_wr_rd.overflow", 32'(f16.overflow), 0);
        check("full_wr_rd.level", 32'(f16.level), 16);
        for (int i = 0; i < 16; i++) begin
            step(0, 8'h00, 1, 0, 0, "drain");
`ifdef SYNC_FIFO_FWFT_EN
            if (i == 14) check("drain.last_is_aa", 32'(f16.rd_data), 32'h0AA);
`else
            if (i == 15) check("drain.last_is_aa", 32'(f16.rd_data), 32'h0AA);
`endif
        end
        $display("seq full_wr_rd: level=%0d overflow=%0d", f16.level, f16.overflow);

        // Empty with simultaneous push+pop: write taken, read refused
        step(1, 8'h33, 1, 0, 0, "empty_wr_rd");
        check("empty_wr_rd.underflow", 32'(f16.underflow), 1);
        check("empty_wr_rd.level", 32'(f16.level), 1);
        $display("seq empty_wr_rd: level=%0d underflow=%0d", f16.level, f16.underflow);

        // Overflow: set beats clear, then clear alone
        for (int i = 0; i < 15; i++) step(1, 8'(i), 0, 0, 0, "refill");
        step(1, 8'h77, 0, 0, 0, "ovf_set");
        step(1, 8'h78, 0, 1, 0, "ovf_set_and_clear");
        check("ovf_set_and_clear.overflow", 32'(f16.overflow), 1);
        step(0, 8'h00, 0, 1, 0, "ovf_clear");
        check("ovf_clear.overflow", 32'(f16.overflow), 0);
        $display("seq ovf_clear: overflow=%0d", f16.overflow);

        // Reset at level 7 with requests active
        do_reset(1'b0);
        for (int i = 0; i < 7; i++) step(1, 8'(8'h40 + i), 0, 0, 0, "lvl7");
        check("lvl7.level", 32'(f16.level), 7);
        do_reset(1'b1);
        $display("seq reset_at_7: level=%0d empty=%0d", f16.level, f16.empty);

        // Write-to-read latency on an empty FIFO
        step(1, 8'h5A, 0, 0, 0, "lat_wr");
        check("lat_wr.empty", 32'(f16.empty), 0);
`ifdef SYNC_FIFO_FWFT_EN
        check("lat_wr.fwft_head", 32'(f16.rd_data), 32'h05A);
        step(0, 8'h00, 1, 0, 0, "lat_pop");
        check("lat_pop.empty", 32'(f16.empty), 1);
`else
        check("lat_wr.rd_data_held", 32'(f16.rd_data), 0);
        step(0, 8'h00, 1, 0, 0, "lat_rd");
        check("lat_rd.rd_data", 32'(f16.rd_data), 32'h05A);
`endif
        $display("seq latency: rd_data=%02h empty=%0d", f16.rd_data, f16.empty);

        // Randomised traffic in three phases: filling, draining, balanced
        wbias[0] = 80;
        wbias[1] = 20;
        wbias[2] = 50;
        do_reset(1'b0);
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 150; c++) begin
                w  = ($urandom_range(0, 99) < wbias[p]);
                r  = ($urandom_range(0, 99) >= wbias[p]);
                co = ($urandom_range(0, 9) == 0);
                cu = ($urandom_range(0, 9) == 0);
                step(w, 8'($urandom), r, co, cu, "rand");
            end
            $display("random phase %0d: level=%0d overflow=%0d underflow=%0d", p, f16.level,
                     f16.overflow, f16.underflow);
        end

        // DEPTH=15: interleaved write/read pairs across the pointer wrap
        do_reset(1'b0);
        wrapped = 1'b0;
        for (int k = 0; k < 40; k++) begin
            prev_wi = 8'(f15.wr_index);
            f15.wr_request = 1'b1;
            f15.wr_data    = 8'(k + 1);
            f15.rd_request = 1'b0;
            @(posedge clk);
            #1;
            if (prev_wi == 8'd14 && f15.wr_index == 4'd0) wrapped = 1'b1;
            check("d15_wr.level", 32'(f15.level), 1);
            check("d15_wr.wr_index", 32'(f15.wr_index), (k + 1) % 15);
`ifdef SYNC_FIFO_FWFT_EN
            check("d15_wr.rd_data", 32'(f15.rd_data), k + 1);
`endif
            f15.wr_request = 1'b0;
            f15.rd_request = 1'b1;
            @(posedge clk);
            #1;
            check("d15_rd.level", 32'(f15.level), 0);
            check("d15_rd.rd_index", 32'(f15.rd_index), (k + 1) % 15);
`ifndef SYNC_FIFO_FWFT_EN
            check("d15_rd.rd_data", 32'(f15.rd_data), k + 1);
`endif
            f15.rd_request = 1'b0;
            $display("d15 pair %0d: wr_index=%0d rd_index=%0d rd_data=%02h", k, f15.wr_index,
                     f15.rd_index, f15.rd_data);
        end
        check("d15.wrap_seen", 32'(wrapped), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
